cr_osf_ob_arb: RTL and testbench
================================

# cr_osf_ob_arb

Frame-granular round-robin arbiter that shares the single OSF outbound AXI4-stream between up to four frame sources (e.g. data frames, CQE/status frames). It grants one source at a time. A grant lasts from the SoT beat through the EoT beat of one frame. Beats are forwarded through a registered output stage, and a frame-count strobe pulses once per delivered frame. It sits between the OSF frame builders and the outbound FIFO / AXI master read path.

## Interface
- N_REQ, 2, number of requesters (legal 2..4)
- DW, 64, data width in bits; strobe width is DW/8
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_tvalid  input  N_REQ  per-source beat valid
- req_tdata  input  N_REQ*DW  per-source data; source i occupies [i*DW +: DW]
- req_tstrb  input  N_REQ*DW/8  per-source byte strobes
- req_tuser  input  N_REQ*2  per-source flags; bit [2i] is SoT, bit [2i+1] is EoT
- req_tready  output  N_REQ  per-source ready
- ob_tvalid  output  1  outbound beat valid (registered)
- ob_tdata  output  DW  outbound data
- ob_tstrb  output  DW/8  outbound strobes
- ob_tuser  output  2  outbound SoT/EoT
- ob_tid  output  2  index of the source that produced the beat
- ob_tready  input  1  outbound ready
- arb_en  input  1  when low, no new grant is issued; an in-flight frame still completes
- arb_idle  output  1  high when state is IDLE and ob_tvalid is 0
- frame_cnt_stb  output  1  one-cycle pulse per EoT beat accepted from a source
- proto_err  output  1  one-cycle pulse on a framing violation

## Operation
- FSM states:
  - IDLE: arbitrate; all req_tready are 0.
  - BUSY: forward beats from the granted source `gnt`.
- Arbitration in IDLE:
  - Runs only when arb_en=1 and at least one req_tvalid is set.
  - Choose the first valid index found by searching rr_ptr, rr_ptr+1, … mod N_REQ.
  - Register the choice into `gnt` and move to BUSY.
  - No selection is made on the cycle the state enters IDLE.
- Output stage:
  - One register slot. `load = !ob_tvalid || ob_tready`.
  - In BUSY: req_tready[gnt] = load; every other req_tready is 0.
  - Source transfer = req_tvalid[gnt] && req_tready[gnt]. On a transfer, the slot loads tdata, tstrb, tuser and ob_tid=gnt, and ob_tvalid sets.
  - If ob_tready=1 and there is no transfer, ob_tvalid clears.
- Frame end:
  - A transfer with EoT=1 (including a single beat with SoT=EoT=1) returns the FSM to IDLE.
  - On that transfer, rr_ptr becomes (gnt+1) mod N_REQ.
  - frame_cnt_stb pulses on the following cycle.
- Framing checks (the beat is still forwarded unchanged in both cases):
  - First transfer of a grant with SoT=0: proto_err pulses.
  - Later transfer of the same frame with SoT=1: proto_err pulses.
- arb_en:
  - Deasserting mid-frame has no effect until EoT.
  - While low, the FSM stays in IDLE after the current frame.
- Reset values: state IDLE, gnt=0, rr_ptr=0. All outputs are 0 except arb_idle=1.
- Reset mid-frame: everything clears asynchronously and any partial frame is abandoned. After reset, arbitration restarts at index 0.

## Timing
- Valid seen in IDLE at cycle t:
  - BUSY and req_tready at t+1.
  - First beat on ob_tvalid at t+2 (2-cycle first-beat latency).
- Within a frame, with ob_tready held at 1:
  - One beat per cycle.
  - 1-cycle latency from source to output.
- Frame-to-frame:
  - EoT transferred at cycle t gives IDLE at t+1 and BUSY at t+2.
  - This leaves exactly one bubble cycle on ob_tvalid.
- Backpressure:
  - With ob_tready=0 and ob_tvalid=1, req_tready drops in the same cycle (combinational from ob_tready).
  - The output register holds its data stable.
- When a req_tvalid and an EoT transfer for a different source occur in the same cycle, the new request is arbitrated in the next IDLE cycle using the updated rr_ptr.

## Test plan
- Single source:
  - Stimulus: source 0 sends a 3-beat frame, data 0xA0..0xA2, SoT on beat 0, EoT on beat 2, ob_tready=1.
  - Response: ob beats at t+2..t+4 with ob_tid=0, one frame_cnt_stb pulse, then arb_idle=1.
- Round-robin:
  - Stimulus: sources 0 and 1 continuously valid with 2-beat frames.
  - Response: ob_tid sequence 0,0,1,1,0,0,1,1 with one bubble between frames and no interleaving within a frame.
- Backpressure:
  - Stimulus: ob_tready toggles 1,0,0,1 during a 4-beat frame.
  - Response: no beat is lost or duplicated, ob_tdata stays stable while stalled, and req_tready follows `load`.
- arb_en:
  - Stimulus: drop arb_en on beat 1 of a 4-beat frame while source 1 is waiting.
  - Response: the frame completes, no grant is issued to source 1, and arb_idle=1.
  - Stimulus: raise arb_en.
  - Response: source 1 is granted on the next cycle.
- Protocol errors:
  - Stimulus: a first beat with SoT=0.
  - Response: one proto_err pulse.
  - Stimulus: a mid-frame beat with SoT=1.
  - Response: one proto_err pulse.
  - In both cases the data is forwarded unchanged.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during beat 2 of a 5-beat frame from source 1.
  - Response: outputs clear immediately; after release with both sources valid, source 0 is granted first.

Source files
------------

// File: rtl/cr_osf_ob_arb_if.sv
// rtl/cr_osf_ob_arb_if.sv - source-side and outbound stream bundle for the OSF outbound arbiter
interface cr_osf_ob_arb_if #(
  parameter int N_REQ = 2,
  parameter int DW    = 64
);
  logic [N_REQ-1:0]      req_tvalid;
  logic [N_REQ*DW-1:0]   req_tdata;
  logic [N_REQ*DW/8-1:0] req_tstrb;
  logic [N_REQ*2-1:0]    req_tuser;
  logic [N_REQ-1:0]      req_tready;
  logic                  ob_tvalid;
  logic [DW-1:0]         ob_tdata;
  logic [DW/8-1:0]       ob_tstrb;
  logic [1:0]            ob_tuser;
  logic [1:0]            ob_tid;
  logic                  ob_tready;

  modport master (
    input  req_tvalid, req_tdata, req_tstrb, req_tuser, ob_tready,
    output req_tready, ob_tvalid, ob_tdata, ob_tstrb, ob_tuser, ob_tid
  );

  modport slave (
    output req_tvalid, req_tdata, req_tstrb, req_tuser, ob_tready,
    input  req_tready, ob_tvalid, ob_tdata, ob_tstrb, ob_tuser, ob_tid
  );
endinterface

// File: rtl/cr_osf_ob_arb.sv
// rtl/cr_osf_ob_arb.sv - frame-granular round-robin arbiter onto the OSF outbound stream
module cr_osf_ob_arb #(
  parameter int N_REQ = 2,
  parameter int DW    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cr_osf_ob_arb_if.master       bus,
  input  logic                  arb_en,
  output logic                  arb_idle,
  output logic                  frame_cnt_stb,
  output logic                  proto_err
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic            first_q, first_d;
  logic            ob_tvalid_q, ob_tvalid_d;
  logic [DW-1:0]   ob_tdata_q, ob_tdata_d;
  logic [DW/8-1:0] ob_tstrb_q, ob_tstrb_d;
  logic [1:0]      ob_tuser_q, ob_tuser_d;
  logic [1:0]      ob_tid_q, ob_tid_d;
  logic            frame_cnt_stb_q, frame_cnt_stb_d;
  logic            proto_err_q, proto_err_d;

  logic            sel_valid;
  logic [DW-1:0]   sel_data;
  logic [DW/8-1:0] sel_strb;
  logic [1:0]      sel_user;
  logic            load;
  logic            xfer;
  logic [N_REQ-1:0] req_tready;
  logic            pick_found;
  logic [1:0]      pick_idx;
  logic [2:0]      cand;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    sel_user  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q == 2'(i)) begin
        sel_valid = bus.req_tvalid[i];
        sel_data  = bus.req_tdata[i*DW +: DW];
        sel_strb  = bus.req_tstrb[i*(DW/8) +: DW/8];
        sel_user  = bus.req_tuser[2*i +: 2];
      end
    end

    // The single output slot can take a new beat when empty or draining this cycle.
    load = !ob_tvalid_q || bus.ob_tready;
    xfer = (state_q == BUSY) && sel_valid && load;

    req_tready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_tready[i] = (state_q == BUSY) && (gnt_q == 2'(i)) && load;
    end

    // Search rr_ptr, rr_ptr+1, ... wrapping at N_REQ; first valid wins.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        if (!pick_found && (cand == 3'(j)) && bus.req_tvalid[j]) begin
          pick_found = 1'b1;
          pick_idx   = 2'(j);
        end
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    rr_ptr_d        = rr_ptr_q;
    first_d         = first_q;
    ob_tvalid_d     = ob_tvalid_q;
    ob_tdata_d      = ob_tdata_q;
    ob_tstrb_d      = ob_tstrb_q;
    ob_tuser_d      = ob_tuser_q;
    ob_tid_d        = ob_tid_q;
    frame_cnt_stb_d = xfer && sel_user[1];
    proto_err_d     = xfer && (first_q ? !sel_user[0] : sel_user[0]);

    case (state_q)
      IDLE: begin
        if (arb_en && pick_found) begin
          state_d = BUSY;
          gnt_d   = pick_idx;
          first_d = 1'b1;
        end
      end
      BUSY: begin
        if (xfer) begin
          first_d = 1'b0;
          if (sel_user[1]) begin
            state_d  = IDLE;
            rr_ptr_d = (gnt_q == 2'(N_REQ-1)) ? 2'd0 : gnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      ob_tvalid_d = 1'b1;
      ob_tdata_d  = sel_data;
      ob_tstrb_d  = sel_strb;
      ob_tuser_d  = sel_user;
      ob_tid_d    = gnt_q;
    end else if (bus.ob_tready) begin
      ob_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      gnt_q           <= '0;
      rr_ptr_q        <= '0;
      first_q         <= 1'b0;
      ob_tvalid_q     <= 1'b0;
      ob_tdata_q      <= '0;
      ob_tstrb_q      <= '0;
      ob_tuser_q      <= '0;
      ob_tid_q        <= '0;
      frame_cnt_stb_q <= 1'b0;
      proto_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      rr_ptr_q        <= rr_ptr_d;
      first_q         <= first_d;
      ob_tvalid_q     <= ob_tvalid_d;
      ob_tdata_q      <= ob_tdata_d;
      ob_tstrb_q      <= ob_tstrb_d;
      ob_tuser_q      <= ob_tuser_d;
      ob_tid_q        <= ob_tid_d;
      frame_cnt_stb_q <= frame_cnt_stb_d;
      proto_err_q     <= proto_err_d;
    end
  end

  assign bus.req_tready = req_tready;
  assign bus.ob_tvalid  = ob_tvalid_q;
  assign bus.ob_tdata   = ob_tdata_q;
  assign bus.ob_tstrb   = ob_tstrb_q;
  assign bus.ob_tuser   = ob_tuser_q;
  assign bus.ob_tid     = ob_tid_q;
  assign arb_idle       = (state_q == IDLE) && !ob_tvalid_q;
  assign frame_cnt_stb  = frame_cnt_stb_q;
  assign proto_err      = proto_err_q;
endmodule

// File: tb/tb_cr_osf_ob_arb.sv
// tb/tb_cr_osf_ob_arb.sv - self-checking bench for the OSF outbound frame arbiter
module tb_cr_osf_ob_arb;
  localparam int N_REQ = 3;
  localparam int DW    = 64;
  localparam int SW    = DW/8;
  localparam int DEPTH = 64;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic arb_en = 1'b0;
  logic arb_idle, frame_cnt_stb, proto_err;

  cr_osf_ob_arb_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  cr_osf_ob_arb #(.N_REQ(N_REQ), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .arb_en        (arb_en),
    .arb_idle      (arb_idle),
    .frame_cnt_stb (frame_cnt_stb),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          sot;
    logic          eot;
    logic          first;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    user;
    logic [1:0]    tid;
  } obeat_t;

  typedef struct {
    logic             vld;
    logic             otr;
    logic [1:0]       tid;
    logic [DW-1:0]    data;
    logic [N_REQ-1:0] rdy;
    logic             idle;
    logic             stb;
    logic             perr;
  } rec_t;

  beat_t            mem [N_REQ][DEPTH];
  int               head [N_REQ];
  int               tail [N_REQ];
  obeat_t           out_q[$];
  obeat_t           exp_q[$];
  rec_t             log_q[$];
  logic [N_REQ-1:0] gap;
  bit               rand_gaps = 0;
  bit               rand_rdy  = 0;
  int               errors = 0;
  int               checks = 0;
  int               stb_cnt = 0;
  int               perr_cnt = 0;

  task automatic drive();
    beat_t b;
    for (int i = 0; i < N_REQ; i++) begin
      if (head[i] != tail[i]) begin
        b = mem[i][head[i]];
        bus.req_tvalid[i]           = !(gap[i] && !b.first);
        bus.req_tdata[i*DW +: DW]   = b.data;
        bus.req_tstrb[i*SW +: SW]   = b.strb;
        bus.req_tuser[2*i +: 2]     = {b.eot, b.sot};
      end else begin
        bus.req_tvalid[i]           = 1'b0;
        bus.req_tdata[i*DW +: DW]   = '0;
        bus.req_tstrb[i*SW +: SW]   = '0;
        bus.req_tuser[2*i +: 2]     = '0;
      end
    end
  endtask

  task automatic clear_logs();
    out_q.delete();
    exp_q.delete();
    log_q.delete();
    stb_cnt  = 0;
    perr_cnt = 0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    gap = '0;
    clear_logs();
  endtask

  task automatic push_frame(input int s, input int len, input logic [DW-1:0] base,
                            input bit first_sot, input int mid_sot);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = base + DW'(k);
      b.strb  = SW'($urandom);
      b.sot   = (k == 0) ? first_sot : (k == mid_sot);
      b.eot   = (k == len - 1);
      b.first = (k == 0);
      mem[s][tail[s]] = b;
      tail[s]++;
    end
  endtask

  // One clock: observe at the falling edge, then update sources just after the rising edge.
  task automatic step();
    rec_t             r;
    obeat_t           o;
    logic [N_REQ-1:0] fire;
    @(negedge clk);
    r.vld  = bus.ob_tvalid;
    r.otr  = bus.ob_tready;
    r.tid  = bus.ob_tid;
    r.data = bus.ob_tdata;
    r.rdy  = bus.req_tready;
    r.idle = arb_idle;
    r.stb  = frame_cnt_stb;
    r.perr = proto_err;
    log_q.push_back(r);
    fire = bus.req_tvalid & bus.req_tready;
    if (bus.ob_tvalid && bus.ob_tready) begin
      o.data = bus.ob_tdata;
      o.user = bus.ob_tuser;
      o.tid  = bus.ob_tid;
      out_q.push_back(o);
    end
    if (frame_cnt_stb) stb_cnt++;
    if (proto_err) perr_cnt++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) if (fire[i]) head[i]++;
    for (int i = 0; i < N_REQ; i++) gap[i] = rand_gaps && ($urandom_range(0, 2) == 0);
    if (rand_rdy) bus.ob_tready = ($urandom_range(0, 3) != 0);
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N_REQ; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run(input int max_cycles, input int nbeats, input string name);
    int n = 0;
    while ((out_q.size() < nbeats || !all_empty()) && n < max_cycles) begin
      step();
      n++;
    end
    repeat (3) step();
    checks++;
    if (n >= max_cycles) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats, required %0d", name, out_q.size(), nbeats);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    arb_en        = 1'b0;
    bus.ob_tready = 1'b0;
    clear_all();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    arb_en        = 1'b1;
    bus.ob_tready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    arb_en        = 1'b0;
    bus.ob_tready = 1'b0;
    clear_all();
    drive();
    #12;
    checks++;
    if ({bus.ob_tvalid, bus.req_tready, frame_cnt_stb, proto_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b rdy=%b stb=%b perr=%b, required all 0",
               bus.ob_tvalid, bus.req_tready, frame_cnt_stb, proto_err);
    end
    checks++;
    if (arb_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got %b required 1", arb_idle);
    end
    checks++;
    if ({bus.ob_tdata, bus.ob_tstrb, bus.ob_tuser, bus.ob_tid} !== '0) begin
      errors++;
      $display("FAIL reset_data: data=%h tid=%0d, required 0", bus.ob_tdata, bus.ob_tid);
    end
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    arb_en        = 1'b1;
    bus.ob_tready = 1'b1;
  endtask

  task automatic test_single_source();
    clear_logs();
    push_frame(0, 3, 64'hA0, 1'b1, -1);
    drive();
    repeat (7) step();
    checks++;
    if (log_q[0].rdy !== '0 || log_q[1].rdy !== 3'b001 || log_q[1].vld !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: rdy t=%b t+1=%b vld t+1=%b, required 000 001 0",
               log_q[0].rdy, log_q[1].rdy, log_q[1].vld);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (log_q[2+k].vld !== 1'b1 || log_q[2+k].tid !== 2'd0 || log_q[2+k].data !== 64'hA0 + 64'(k)) begin
        errors++;
        $display("FAIL single_beat%0d: vld=%b tid=%0d data=%h, required 1 0 %h",
                 k, log_q[2+k].vld, log_q[2+k].tid, log_q[2+k].data, 64'hA0 + 64'(k));
      end
    end
    checks++;
    if (log_q[4].stb !== 1'b1 || stb_cnt != 1) begin
      errors++;
      $display("FAIL single_stb: at t+4=%b count=%0d, required 1 1", log_q[4].stb, stb_cnt);
    end
    checks++;
    if (log_q[5].idle !== 1'b1 || log_q[5].vld !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: idle=%b vld=%b, required 1 0", log_q[5].idle, log_q[5].vld);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]    etid [8];
    logic [DW-1:0] edat [8];
    int            f;
    do_reset();
    push_frame(0, 2, 64'h100, 1'b1, -1);
    push_frame(0, 2, 64'h110, 1'b1, -1);
    push_frame(1, 2, 64'h200, 1'b1, -1);
    push_frame(1, 2, 64'h210, 1'b1, -1);
    drive();
    repeat (16) step();
    etid = '{0, 0, 1, 1, 0, 0, 1, 1};
    edat = '{64'h100, 64'h101, 64'h200, 64'h201, 64'h110, 64'h111, 64'h210, 64'h211};
    checks++;
    if (out_q.size() != 8) begin
      errors++;
      $display("FAIL rr_count: got %0d beats, required 8", out_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (out_q[k].tid !== etid[k] || out_q[k].data !== edat[k]) begin
          errors++;
          $display("FAIL rr_beat%0d: tid=%0d data=%h, required %0d %h",
                   k, out_q[k].tid, out_q[k].data, etid[k], edat[k]);
        end
      end
    end
    f = 0;
    while (f < log_q.size() - 12 && log_q[f].vld !== 1'b1) f++;
    for (int j = 0; j < 11; j++) begin
      checks++;
      if (log_q[f+j].vld !== ((j % 3) != 2)) begin
        errors++;
        $display("FAIL rr_bubble%0d: vld=%b, required %b", j, log_q[f+j].vld, (j % 3) != 2);
      end
    end
  endtask

  task automatic test_backpressure();
    bit pat [4];
    int pi;
    int stalls;
    pat = '{1, 0, 0, 1};
    pi  = -1;
    clear_logs();
    bus.ob_tready = 1'b1;
    push_frame(0, 4, 64'h300, 1'b1, -1);
    drive();
    for (int c = 0; c < 16; c++) begin
      step();
      if (pi < 0 && log_q[log_q.size()-1].vld === 1'b1) pi = 1;
      if (pi >= 1 && pi < 4) begin
        bus.ob_tready = pat[pi];
        pi++;
      end else begin
        bus.ob_tready = 1'b1;
      end
    end
    checks++;
    if (out_q.size() != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d beats, required 4", out_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (out_q[k].data !== 64'h300 + 64'(k)) begin
          errors++;
          $display("FAIL bp_beat%0d: data=%h, required %h", k, out_q[k].data, 64'h300 + 64'(k));
        end
      end
    end
    stalls = 0;
    for (int j = 1; j < log_q.size(); j++) begin
      if (log_q[j].vld === 1'b1 && log_q[j].otr === 1'b0) begin
        stalls++;
        checks++;
        if (log_q[j].rdy !== '0) begin
          errors++;
          $display("FAIL bp_ready%0d: rdy=%b, required 000", j, log_q[j].rdy);
        end
      end
      if (log_q[j-1].vld === 1'b1 && log_q[j-1].otr === 1'b0) begin
        checks++;
        if (log_q[j].vld !== 1'b1 || log_q[j].data !== log_q[j-1].data) begin
          errors++;
          $display("FAIL bp_hold%0d: vld=%b data=%h, required 1 %h",
                   j, log_q[j].vld, log_q[j].data, log_q[j-1].data);
        end
      end
    end
    checks++;
    if (stalls != 2) begin
      errors++;
      $display("FAIL bp_stalls: got %0d stalled cycles, required 2", stalls);
    end
  endtask

  task automatic test_arb_en();
    int n;
    int after;
    do_reset();
    push_frame(0, 4, 64'h400, 1'b1, -1);
    push_frame(1, 2, 64'h500, 1'b1, -1);
    drive();
    n = 0;
    after = 0;
    while (after < 6 && n < 40) begin
      step();
      n++;
      if (log_q[log_q.size()-1].vld === 1'b1 && log_q[log_q.size()-1].data === 64'h401) arb_en = 1'b0;
      if (head[0] == tail[0]) after++;
    end
    checks++;
    if (out_q.size() != 4 || head[1] != 0) begin
      errors++;
      $display("FAIL arben_hold: beats=%0d src1_taken=%0d, required 4 0", out_q.size(), head[1]);
    end
    for (int k = 0; k < out_q.size(); k++) begin
      checks++;
      if (out_q[k].tid !== 2'd0 || out_q[k].data !== 64'h400 + 64'(k)) begin
        errors++;
        $display("FAIL arben_beat%0d: tid=%0d data=%h, required 0 %h",
                 k, out_q[k].tid, out_q[k].data, 64'h400 + 64'(k));
      end
    end
    checks++;
    if (log_q[log_q.size()-1].idle !== 1'b1 || log_q[log_q.size()-1].rdy !== '0) begin
      errors++;
      $display("FAIL arben_idle: idle=%b rdy=%b, required 1 000",
               log_q[log_q.size()-1].idle, log_q[log_q.size()-1].rdy);
    end
    arb_en = 1'b1;
    step();
    step();
    checks++;
    if (log_q[log_q.size()-2].rdy !== '0 || log_q[log_q.size()-1].rdy !== 3'b010) begin
      errors++;
      $display("FAIL arben_regrant: rdy t=%b t+1=%b, required 000 010",
               log_q[log_q.size()-2].rdy, log_q[log_q.size()-1].rdy);
    end
    run(50, 6, "arben");
    checks++;
    if (out_q.size() != 6 || out_q[4].tid !== 2'd1 || out_q[5].data !== 64'h501) begin
      errors++;
      $display("FAIL arben_src1: beats=%0d, required 6 with src1 last", out_q.size());
    end
  endtask

  task automatic test_proto_err();
    clear_logs();
    push_frame(0, 2, 64'h600, 1'b0, -1);
    drive();
    run(50, 2, "perr_first");
    checks++;
    if (perr_cnt != 1 || stb_cnt != 1) begin
      errors++;
      $display("FAIL perr_first: perr=%0d stb=%0d, required 1 1", perr_cnt, stb_cnt);
    end
    checks++;
    if (out_q.size() != 2 || out_q[0].user !== 2'b00 || out_q[0].data !== 64'h600 ||
        out_q[1].user !== 2'b10 || out_q[1].data !== 64'h601) begin
      errors++;
      $display("FAIL perr_first_fwd: beats=%0d, required 2 unchanged", out_q.size());
    end
    clear_logs();
    push_frame(0, 3, 64'h700, 1'b1, 1);
    drive();
    run(50, 3, "perr_mid");
    checks++;
    if (perr_cnt != 1 || stb_cnt != 1) begin
      errors++;
      $display("FAIL perr_mid: perr=%0d stb=%0d, required 1 1", perr_cnt, stb_cnt);
    end
    checks++;
    if (out_q.size() != 3 || out_q[0].user !== 2'b01 || out_q[1].user !== 2'b01 ||
        out_q[2].user !== 2'b10 || out_q[1].data !== 64'h701) begin
      errors++;
      $display("FAIL perr_mid_fwd: beats=%0d, required 3 unchanged", out_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    do_reset();
    push_frame(1, 5, 64'h800, 1'b1, -1);
    drive();
    n = 0;
    while (!(log_q.size() > 0 && log_q[log_q.size()-1].data === 64'h802) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL rstmid_reach: beat 2 not seen within 20 cycles, required seen");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ob_tvalid !== 1'b0 || bus.req_tready !== '0 || arb_idle !== 1'b1 ||
        bus.ob_tdata !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: vld=%b rdy=%b idle=%b data=%h, required 0 000 1 0",
               bus.ob_tvalid, bus.req_tready, arb_idle, bus.ob_tdata);
    end
    @(posedge clk);
    #1;
    clear_all();
    push_frame(0, 2, 64'h900, 1'b1, -1);
    push_frame(1, 2, 64'h910, 1'b1, -1);
    drive();
    rst_n = 1'b1;
    run(50, 4, "rstmid");
    checks++;
    if (out_q.size() != 4 || out_q[0].tid !== 2'd0 || out_q[0].data !== 64'h900 ||
        out_q[2].tid !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_order: beats=%0d first_tid=%0d, required 4 0", out_q.size(),
               (out_q.size() > 0) ? out_q[0].tid : 2'd3);
    end
  endtask

  task automatic test_random();
    int     flen [N_REQ][4];
    int     fcnt [N_REQ];
    int     fidx [N_REQ];
    int     pos  [N_REQ];
    int     total;
    int     p;
    int     s;
    obeat_t o;
    for (int iter = 0; iter < 4; iter++) begin
      do_reset();
      total = 0;
      for (int i = 0; i < N_REQ; i++) begin
        fcnt[i] = $urandom_range(1, 4);
        fidx[i] = 0;
        pos[i]  = 0;
        for (int k = 0; k < fcnt[i]; k++) begin
          flen[i][k] = $urandom_range(1, 5);
          push_frame(i, flen[i][k], {$urandom, $urandom}, 1'b1, -1);
        end
        total += fcnt[i];
      end
      // Reference: whole frames in round-robin order starting from source 0.
      p = 0;
      for (int f = 0; f < total; f++) begin
        s = -1;
        for (int k = 0; k < N_REQ && s < 0; k++)
          if (fidx[(p + k) % N_REQ] < fcnt[(p + k) % N_REQ]) s = (p + k) % N_REQ;
        for (int b = 0; b < flen[s][fidx[s]]; b++) begin
          o.data = mem[s][pos[s] + b].data;
          o.user = {mem[s][pos[s] + b].eot, mem[s][pos[s] + b].sot};
          o.tid  = 2'(s);
          exp_q.push_back(o);
        end
        pos[s] += flen[s][fidx[s]];
        fidx[s]++;
        p = (s + 1) % N_REQ;
      end
      rand_gaps = 1;
      rand_rdy  = 1;
      drive();
      run(3000, exp_q.size(), "rand");
      rand_gaps     = 0;
      rand_rdy      = 0;
      bus.ob_tready = 1'b1;
      checks++;
      if (out_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d beats, required %0d", iter, out_q.size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          checks++;
          if (out_q[k].data !== exp_q[k].data || out_q[k].user !== exp_q[k].user ||
              out_q[k].tid !== exp_q[k].tid) begin
            errors++;
            $display("FAIL rand%0d_beat%0d: tid=%0d user=%b data=%h, required %0d %b %h", iter, k,
                     out_q[k].tid, out_q[k].user, out_q[k].data,
                     exp_q[k].tid, exp_q[k].user, exp_q[k].data);
          end
        end
      end
      checks++;
      if (stb_cnt != total || perr_cnt != 0) begin
        errors++;
        $display("FAIL rand%0d_counts: stb=%0d perr=%0d, required %0d 0", iter, stb_cnt, perr_cnt, total);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_arb_en();
    test_proto_err();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
